// File: rtl/adat_rx_bit_decoder.sv
// adat_rx_bit_decoder
//   Turns the edge-to-edge intervals reported by adat_rx_timing_tracker into
//   the NRZI-decoded serial bit stream of an ADAT frame. Each interval of n
//   cells produces n-1 zeros followed by a one. An 11-cell interval is the
//   sync gap: it locks the decoder, restarts the per-frame bit counter and
//   marks the next emitted bit as the start of a frame.
//
// Ports
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_edge               one-cycle pulse per input transition
//   i_edge_time          clocks since the previous edge (valid with i_edge)
//   i_max_time           sync-interval length M in clocks (SYNC_CELLS cells)
//   o_bit, o_bit_valid   decoded bit and its qualifier (at most one per cycle)
//   o_frame_start        high with the first valid bit after a sync
//   o_bit_count          bits emitted since the last sync, saturating at 255
//   o_locked             sync seen and no interval/overflow error since
//   o_interval_err       pulse: interval shorter than half a cell or too long
//   o_ovf_err            pulse: interval queue overflow
//   o_frame_err          pulse: sync while locked with a wrong bit count
//   o_err_count          (ADAT_RX_BIT_DECODER_STATS_EN only) saturating count
//                        of cycles in which any error pulse is high
//
// Build option: define ADAT_RX_BIT_DECODER_STATS_EN to add o_err_count.

module adat_rx_bit_decoder #(
  parameter int unsigned EDGE_TIME_W = 12,
  parameter int unsigned MAX_TIME_W  = 10,
  parameter int unsigned SYNC_CELLS  = 11,
  parameter int unsigned FRAME_BITS  = 256
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_edge,
  input  logic [EDGE_TIME_W-1:0] i_edge_time,
  input  logic [MAX_TIME_W-1:0]  i_max_time,
  output logic                   o_bit,
  output logic                   o_bit_valid,
  output logic                   o_frame_start,
  output logic [7:0]             o_bit_count,
  output logic                   o_locked,
  output logic                   o_interval_err,
  output logic                   o_ovf_err,
  output logic                   o_frame_err
`ifdef ADAT_RX_BIT_DECODER_STATS_EN
  ,
  output logic [15:0]            o_err_count
`endif
);

  localparam int unsigned N_W    = $clog2(SYNC_CELLS + 2);
  localparam int unsigned T_MULT = 2 * SYNC_CELLS;
  localparam int unsigned CMP_W  = ((EDGE_TIME_W > MAX_TIME_W) ? EDGE_TIME_W : MAX_TIME_W)
                                   + $clog2(2 * SYNC_CELLS + 2) + 1;
  localparam logic [7:0]  GOOD_COUNT = 8'(FRAME_BITS - SYNC_CELLS);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  // ---------------------------------------------------------------------
  // Interval classification. n is the number of odd multiples (1,3,..,23)*M
  // that 22*T reaches, so n=0 is "too short" and n=SYNC_CELLS+1 "too long".
  // ---------------------------------------------------------------------
  logic [CMP_W-1:0] t_scaled;
  logic [CMP_W-1:0] th;
  logic [CMP_W-1:0] th_step;
  logic [N_W-1:0]   n_cls;
  logic             is_err;
  logic             is_sync;

  always_comb begin
    t_scaled = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (T_MULT[b]) t_scaled = t_scaled + (CMP_W'(i_edge_time) << b);
    end
    th      = CMP_W'(i_max_time);
    th_step = CMP_W'(i_max_time) << 1;
    n_cls   = '0;
    for (int unsigned j = 0; j <= SYNC_CELLS; j++) begin
      if (t_scaled >= th) n_cls = n_cls + N_W'(1);
      th = th + th_step;
    end
    is_err  = (n_cls == '0) || (n_cls > N_W'(SYNC_CELLS));
    is_sync = (n_cls == N_W'(SYNC_CELLS));
  end

  // ---------------------------------------------------------------------
  // State, 2-entry interval queue and emitter
  // ---------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [N_W-1:0] q0_q, q0_d, q1_q, q1_d;
  logic [1:0]     qc_q, qc_d;
  logic [N_W-1:0] cnt_q, cnt_d;
  logic           act_q, act_d;
  logic           fs_flag_q, fs_flag_d;
  logic           bit_q, bit_d;
  logic           valid_q, valid_d;
  logic           fs_out_q, fs_out_d;
  logic [7:0]     bc_q, bc_d;
  logic [7:0]     bc_inc;
  logic           ierr_q, ierr_d;
  logic           oerr_q, oerr_d;
  logic           ferr_q, ferr_d;
  logic           pop;

  always_comb begin
    state_d   = state_q;
    q0_d      = q0_q;
    q1_d      = q1_q;
    qc_d      = qc_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    fs_flag_d = fs_flag_q;
    bit_d     = 1'b0;
    valid_d   = 1'b0;
    fs_out_d  = 1'b0;
    bc_inc    = bc_q;
    bc_d      = bc_q;
    ierr_d    = 1'b0;
    oerr_d    = 1'b0;
    ferr_d    = 1'b0;
    pop       = 1'b0;

    // The interval being counted stays at the queue head until its final
    // '1' is emitted, so the queue occupancy includes the active interval.
    if (act_q) begin
      valid_d = 1'b1;
      bit_d   = (cnt_q == N_W'(1));
      if (bit_d) pop = 1'b1;
      else       cnt_d = cnt_q - N_W'(1);
    end

    if (pop) begin
      q0_d = q1_q;
      qc_d = qc_q - 2'd1;
      if (qc_d != 2'd0) cnt_d = q1_q;
      else              act_d = 1'b0;
    end else if (!act_q && qc_q != 2'd0) begin
      cnt_d = q0_q;
      act_d = 1'b1;
    end

    if (valid_d) begin
      fs_out_d  = fs_flag_q;
      fs_flag_d = 1'b0;
      if (bc_q != 8'hFF) bc_inc = bc_q + 8'd1;
    end
    bc_d = bc_inc;

    if (i_edge) begin
      if (is_err) begin
        ierr_d  = 1'b1;
        state_d = UNLOCKED;
      end else if (is_sync) begin
        // A bit emitted this same cycle still belongs to the old frame.
        if (state_q == LOCKED && bc_inc != GOOD_COUNT) ferr_d = 1'b1;
        bc_d      = '0;
        fs_flag_d = 1'b1;
        state_d   = LOCKED;
      end else if (state_q == LOCKED) begin
        if (qc_d == 2'd2) begin
          oerr_d  = 1'b1;
          state_d = UNLOCKED;
          qc_d    = '0;
          act_d   = 1'b0;
        end else begin
          if (qc_d == 2'd0) q0_d = n_cls;
          else              q1_d = n_cls;
          qc_d = qc_d + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= UNLOCKED;
      q0_q      <= '0;
      q1_q      <= '0;
      qc_q      <= '0;
      cnt_q     <= '0;
      act_q     <= 1'b0;
      fs_flag_q <= 1'b0;
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
      fs_out_q  <= 1'b0;
      bc_q      <= '0;
      ierr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q0_q      <= q0_d;
      q1_q      <= q1_d;
      qc_q      <= qc_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      fs_flag_q <= fs_flag_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      fs_out_q  <= fs_out_d;
      bc_q      <= bc_d;
      ierr_q    <= ierr_d;
      oerr_q    <= oerr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign o_bit          = bit_q;
  assign o_bit_valid    = valid_q;
  assign o_frame_start  = fs_out_q;
  assign o_bit_count    = bc_q;
  assign o_locked       = (state_q == LOCKED);
  assign o_interval_err = ierr_q;
  assign o_ovf_err      = oerr_q;
  assign o_frame_err    = ferr_q;

`ifdef ADAT_RX_BIT_DECODER_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((ierr_q || oerr_q || ferr_q) && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign o_err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_adat_rx_bit_decoder.sv
// Directed bench for adat_rx_bit_decoder (default build, stats disabled).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_adat_rx_bit_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_edge = 1'b0;
  logic [11:0] i_edge_time = '0;
  logic [9:0]  i_max_time = 10'd110;
  logic        o_bit, o_bit_valid, o_frame_start, o_locked;
  logic        o_interval_err, o_ovf_err, o_frame_err;
  logic [7:0]  o_bit_count;

  int n_checks = 0;
  int n_fail   = 0;
  int nbits    = 0;
  int nones    = 0;

  adat_rx_bit_decoder dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_edge         (i_edge),
    .i_edge_time    (i_edge_time),
    .i_max_time     (i_max_time),
    .o_bit          (o_bit),
    .o_bit_valid    (o_bit_valid),
    .o_frame_start  (o_frame_start),
    .o_bit_count    (o_bit_count),
    .o_locked       (o_locked),
    .o_interval_err (o_interval_err),
    .o_ovf_err      (o_ovf_err),
    .o_frame_err    (o_frame_err)
  );

  always #5 clk = ~clk;

  // Running tally of emitted bits, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (o_bit_valid) begin
      nbits++;
      if (o_bit) nones++;
    end
  end

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One-cycle edge pulse; returns on the falling edge after it was sampled.
  task automatic pulse_edge(input logic [11:0] t);
    @(negedge clk);
    i_edge = 1'b1;
    i_edge_time = t;
    @(negedge clk);
    i_edge = 1'b0;
  endtask

  task automatic test_reset;
    wait_neg(2);
    n_checks++; if ({o_bit, o_bit_valid, o_frame_start, o_bit_count, o_locked, o_interval_err, o_ovf_err, o_frame_err} !== 15'd0) begin n_fail++; $display("FAIL reset_outputs: got %b required 0", {o_bit, o_bit_valid, o_frame_start, o_bit_count, o_locked, o_interval_err, o_ovf_err, o_frame_err}); end
    rst = 1'b0;
    wait_neg(1);
  endtask

  task automatic test_unlocked;
    int b0;
    b0 = nbits;
    pulse_edge(12'd30);
    wait_neg(6);
    n_checks++; if (nbits !== b0) begin n_fail++; $display("FAIL unlocked_drop_bits: got %0d required %0d", nbits - b0, 0); end
    n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL unlocked_stays: got %b required 0", o_locked); end
    pulse_edge(12'd110);
    n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL lock_on_sync: got %b required 1", o_locked); end
    n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL sync_unlocked_no_ferr: got %b required 0", o_frame_err); end
    wait_neg(4);
    n_checks++; if (nbits !== b0) begin n_fail++; $display("FAIL sync_no_bits: got %0d required %0d", nbits - b0, 0); end
    n_checks++; if (o_bit_count !== 8'd0) begin n_fail++; $display("FAIL sync_count_zero: got %0d required 0", o_bit_count); end
  endtask

  task automatic test_basic_bits;
    pulse_edge(12'd30);
    n_checks++; if (o_bit_valid !== 1'b0) begin n_fail++; $display("FAIL lat_c1_idle: got %b required 0", o_bit_valid); end
    wait_neg(1);
    n_checks++; if (o_bit_valid !== 1'b0) begin n_fail++; $display("FAIL lat_c2_idle: got %b required 0", o_bit_valid); end
    wait_neg(1);
    n_checks++; if ({o_bit_valid, o_bit, o_frame_start} !== 3'b101) begin n_fail++; $display("FAIL bit0_valid_bit_fs: got %b required 101", {o_bit_valid, o_bit, o_frame_start}); end
    n_checks++; if (o_bit_count !== 8'd1) begin n_fail++; $display("FAIL bit0_count: got %0d required 1", o_bit_count); end
    wait_neg(1);
    n_checks++; if ({o_bit_valid, o_bit, o_frame_start} !== 3'b100) begin n_fail++; $display("FAIL bit1_valid_bit_fs: got %b required 100", {o_bit_valid, o_bit, o_frame_start}); end
    wait_neg(1);
    n_checks++; if ({o_bit_valid, o_bit, o_frame_start} !== 3'b110) begin n_fail++; $display("FAIL bit2_valid_bit_fs: got %b required 110", {o_bit_valid, o_bit, o_frame_start}); end
    n_checks++; if (o_bit_count !== 8'd3) begin n_fail++; $display("FAIL bit2_count: got %0d required 3", o_bit_count); end
    wait_neg(1);
    n_checks++; if (o_bit_valid !== 1'b0) begin n_fail++; $display("FAIL after_interval_idle: got %b required 0", o_bit_valid); end
  endtask

  task automatic test_frame_ok;
    int b0, o0;
    // Bit count is 3 here, so this sync closes a short frame.
    pulse_edge(12'd110);
    n_checks++; if (o_frame_err !== 1'b1) begin n_fail++; $display("FAIL short_frame_ferr: got %b required 1", o_frame_err); end
    b0 = nbits; o0 = nones;
    for (int i = 0; i < 24; i++) begin
      pulse_edge(12'd100);
      wait_neg(11);
    end
    pulse_edge(12'd50);
    wait_neg(8);
    n_checks++; if (o_bit_count !== 8'd245) begin n_fail++; $display("FAIL frame_count_245: got %0d required 245", o_bit_count); end
    n_checks++; if (nbits - b0 !== 245) begin n_fail++; $display("FAIL frame_bits_245: got %0d required 245", nbits - b0); end
    n_checks++; if (nones - o0 !== 25) begin n_fail++; $display("FAIL frame_ones_25: got %0d required 25", nones - o0); end
    pulse_edge(12'd110);
    n_checks++; if ({o_frame_err, o_locked} !== 2'b01) begin n_fail++; $display("FAIL good_frame_ferr_lock: got %b required 01", {o_frame_err, o_locked}); end
    n_checks++; if (o_bit_count !== 8'd0) begin n_fail++; $display("FAIL good_frame_count_clear: got %0d required 0", o_bit_count); end
  endtask

  task automatic test_frame_err;
    for (int i = 0; i < 10; i++) begin
      pulse_edge(12'd100);
      wait_neg(11);
    end
    n_checks++; if (o_bit_count !== 8'd100) begin n_fail++; $display("FAIL count_100: got %0d required 100", o_bit_count); end
    pulse_edge(12'd110);
    n_checks++; if ({o_frame_err, o_locked} !== 2'b11) begin n_fail++; $display("FAIL ferr_pulse_lock: got %b required 11", {o_frame_err, o_locked}); end
    wait_neg(1);
    n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_one_cycle: got %b required 0", o_frame_err); end
    pulse_edge(12'd10);
    wait_neg(2);
    n_checks++; if ({o_bit_valid, o_bit, o_frame_start} !== 3'b111) begin n_fail++; $display("FAIL fs_after_ferr: got %b required 111", {o_bit_valid, o_bit, o_frame_start}); end
    wait_neg(2);
  endtask

  task automatic test_back_to_back_overflow;
    int b0;
    @(negedge clk);
    i_edge = 1'b1; i_edge_time = 12'd100;
    wait_neg(3);
    i_edge = 1'b0;
    n_checks++; if ({o_ovf_err, o_locked} !== 2'b10) begin n_fail++; $display("FAIL ovf_pulse_unlock: got %b required 10", {o_ovf_err, o_locked}); end
    n_checks++; if ({o_bit_valid, o_bit} !== 2'b10) begin n_fail++; $display("FAIL ovf_first_bit: got %b required 10", {o_bit_valid, o_bit}); end
    b0 = nbits;
    wait_neg(1);
    n_checks++; if (o_ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %b required 0", o_ovf_err); end
    wait_neg(14);
    n_checks++; if (nbits !== b0) begin n_fail++; $display("FAIL ovf_flushed: got %0d required %0d", nbits - b0, 0); end
  endtask

  task automatic test_interval_err;
    pulse_edge(12'd110);
    n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL relock: got %b required 1", o_locked); end
    pulse_edge(12'd4);
    n_checks++; if ({o_interval_err, o_locked} !== 2'b10) begin n_fail++; $display("FAIL ierr_pulse_unlock: got %b required 10", {o_interval_err, o_locked}); end
    wait_neg(1);
    n_checks++; if (o_interval_err !== 1'b0) begin n_fail++; $display("FAIL ierr_one_cycle: got %b required 0", o_interval_err); end
  endtask

  // M=22 puts the classification thresholds on integer T: 22T >= (2k-1)*22.
  task automatic test_boundaries;
    @(negedge clk);
    i_max_time = 10'd22;
    pulse_edge(12'd21);
    n_checks++; if ({o_interval_err, o_locked} !== 2'b01) begin n_fail++; $display("FAIL sync_low_edge: got %b required 01", {o_interval_err, o_locked}); end
    pulse_edge(12'd23);
    n_checks++; if ({o_interval_err, o_locked} !== 2'b10) begin n_fail++; $display("FAIL too_long_edge: got %b required 10", {o_interval_err, o_locked}); end
    pulse_edge(12'd22);
    n_checks++; if ({o_interval_err, o_locked} !== 2'b01) begin n_fail++; $display("FAIL sync_high_edge: got %b required 01", {o_interval_err, o_locked}); end
    pulse_edge(12'd1);
    wait_neg(2);
    n_checks++; if ({o_bit_valid, o_bit, o_frame_start} !== 3'b111) begin n_fail++; $display("FAIL n1_low_edge: got %b required 111", {o_bit_valid, o_bit, o_frame_start}); end
    pulse_edge(12'd0);
    n_checks++; if ({o_interval_err, o_locked} !== 2'b10) begin n_fail++; $display("FAIL zero_interval: got %b required 10", {o_interval_err, o_locked}); end
    @(negedge clk);
    i_max_time = 10'd110;
  endtask

  task automatic test_async_reset;
    int b0;
    pulse_edge(12'd110);
    pulse_edge(12'd100);
    wait_neg(3);
    n_checks++; if (o_bit_valid !== 1'b1) begin n_fail++; $display("FAIL mid_emission: got %b required 1", o_bit_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({o_bit, o_bit_valid, o_frame_start, o_bit_count, o_locked, o_interval_err, o_ovf_err, o_frame_err} !== 15'd0) begin n_fail++; $display("FAIL async_reset_outputs: got %b required 0", {o_bit, o_bit_valid, o_frame_start, o_bit_count, o_locked, o_interval_err, o_ovf_err, o_frame_err}); end
    @(negedge clk);
    rst = 1'b0;
    b0 = nbits;
    wait_neg(12);
    n_checks++; if (nbits !== b0) begin n_fail++; $display("FAIL reset_clears_queue: got %0d required %0d", nbits - b0, 0); end
  endtask

  initial begin
    test_reset();
    test_unlocked();
    test_basic_bits();
    test_frame_ok();
    test_frame_err();
    test_back_to_back_overflow();
    test_interval_err();
    test_boundaries();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
